// File: rtl/calc_pkg.sv
// Shared scancodes, operator/state encodings, widths and small helpers for the calculator.
// Optional macro DIV_EN adds the divide key, the DIV state and the divider constants.
package calc_pkg;

  localparam int unsigned OPW         = 7;
  localparam int unsigned RESW        = 14;
  localparam int unsigned BCDW        = 16;
  localparam int unsigned CONV_CYCLES = 14;
  localparam int unsigned CNTW        = 4;
  localparam int unsigned MAX_DIGITS  = 2;
  localparam int unsigned DIGW        = 2;
`ifdef DIV_EN
  localparam int unsigned DIV_CYCLES  = 7;
  localparam int unsigned DIVCNTW     = 3;
`endif

  localparam logic [7:0] KEY_0     = 8'h45;
  localparam logic [7:0] KEY_1     = 8'h16;
  localparam logic [7:0] KEY_2     = 8'h1E;
  localparam logic [7:0] KEY_3     = 8'h26;
  localparam logic [7:0] KEY_4     = 8'h25;
  localparam logic [7:0] KEY_5     = 8'h2E;
  localparam logic [7:0] KEY_6     = 8'h36;
  localparam logic [7:0] KEY_7     = 8'h3D;
  localparam logic [7:0] KEY_8     = 8'h3E;
  localparam logic [7:0] KEY_9     = 8'h46;
  localparam logic [7:0] KEY_ADD   = 8'h79;
  localparam logic [7:0] KEY_SUB   = 8'h7B;
  localparam logic [7:0] KEY_MUL   = 8'h22;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_ESC   = 8'h76;
`ifdef DIV_EN
  localparam logic [7:0] KEY_DIV   = 8'h4A;
`endif

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_ENTER_A,
    ST_ENTER_B,
    ST_CALC,
    ST_CONVERT,
    ST_SHOW
`ifdef DIV_EN
    , ST_DIV
`endif
  } state_e;

  typedef struct packed {
    logic       hit;
    logic [3:0] val;
  } digit_t;

  typedef struct packed {
    logic hit;
    op_e  op;
  } opkey_t;

  function automatic digit_t decode_digit(input logic [7:0] code);
    digit_t d;
    d.hit = 1'b1;
    d.val = 4'd0;
    case (code)
      KEY_0: d.val = 4'd0;
      KEY_1: d.val = 4'd1;
      KEY_2: d.val = 4'd2;
      KEY_3: d.val = 4'd3;
      KEY_4: d.val = 4'd4;
      KEY_5: d.val = 4'd5;
      KEY_6: d.val = 4'd6;
      KEY_7: d.val = 4'd7;
      KEY_8: d.val = 4'd8;
      KEY_9: d.val = 4'd9;
      default: d.hit = 1'b0;
    endcase
    return d;
  endfunction

  function automatic opkey_t decode_op(input logic [7:0] code);
    opkey_t o;
    o.hit = 1'b1;
    o.op  = OP_ADD;
    case (code)
      KEY_ADD: o.op = OP_ADD;
      KEY_SUB: o.op = OP_SUB;
      KEY_MUL: o.op = OP_MUL;
`ifdef DIV_EN
      KEY_DIV: o.op = OP_DIV;
`endif
      default: o.hit = 1'b0;
    endcase
    return o;
  endfunction

  function automatic logic [OPW-1:0] push_digit(input logic [OPW-1:0] v, input logic [3:0] d);
    return OPW'(v * OPW'(10)) + OPW'(d);
  endfunction

  // Entry display: the first digit lands in the units, a second shifts it to the tens.
  function automatic logic [BCDW-1:0] show_operand(input logic [BCDW-1:0] cur,
                                                   input logic [DIGW-1:0] cnt,
                                                   input logic [3:0]      d);
    if (cnt == '0) return BCDW'(d);
    return {8'h00, cur[3:0], d};
  endfunction

  // Double-dabble correction: add 3 to every BCD digit of 5 or more before the shift.
  function automatic logic [BCDW-1:0] dd_adjust(input logic [BCDW-1:0] b);
    logic [BCDW-1:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: 14-bit binary to four BCD digits, one bit per clock.
// The first shift happens on the start edge, so done_o rises CONV_CYCLES cycles after start_i.
module bin2bcd_seq
  import calc_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [RESW-1:0] bin_i,
  output logic            done_o,
  output logic [BCDW-1:0] bcd_o
);

  logic            run_q;
  logic            done_q;
  logic [CNTW-1:0] cnt_q;
  logic [RESW-1:0] bin_q;
  logic [BCDW-1:0] bcd_q;
  logic [BCDW-1:0] adj_c;

  assign adj_c  = dd_adjust(bcd_q);
  assign done_o = done_q;
  assign bcd_o  = bcd_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q  <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      bin_q  <= '0;
      bcd_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        bcd_q <= BCDW'(bin_i[RESW-1]);
        bin_q <= {bin_i[RESW-2:0], 1'b0};
        cnt_q <= CNTW'(CONV_CYCLES - 1);
        run_q <= 1'b1;
      end else if (run_q) begin
        bcd_q <= {adj_c[BCDW-2:0], bin_q[RESW-1]};
        bin_q <= {bin_q[RESW-2:0], 1'b0};
        cnt_q <= cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Keystroke calculator sequencer: two 2-digit operands, operator, Enter, BCD result.
// Optional macro DIV_EN enables the divide key and a 7-cycle restoring divider.
module calc_sequencer
  import calc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  key_code,
  input  logic        key_valid,
  output logic [15:0] bcd,
  output logic        neg,
  output logic [1:0]  op,
  output logic        busy,
  output logic        result_valid,
  output logic        err
);

  state_e          state_q;
  logic [OPW-1:0]  a_q;
  logic [OPW-1:0]  b_q;
  logic [DIGW-1:0] acnt_q;
  logic [DIGW-1:0] bcnt_q;
  op_e             op_q;
  logic [BCDW-1:0] bcd_q;
  logic            neg_q;
  logic            busy_q;
  logic            rv_q;

  logic            key_c;
  digit_t          dig_c;
  opkey_t          opk_c;
  logic [RESW-1:0] res_c;
  logic            neg_c;
  logic            conv_start_c;
  logic [RESW-1:0] conv_bin_c;
  logic            conv_done;
  logic [BCDW-1:0] conv_bcd;

  assign key_c = key_valid && !busy_q;
  assign dig_c = decode_digit(key_code);
  assign opk_c = decode_op(key_code);

  // Add/sub/mul result magnitude and sign, consumed in CALC.
  always_comb begin
    res_c = '0;
    neg_c = 1'b0;
    case (op_q)
      OP_ADD: res_c = RESW'(a_q) + RESW'(b_q);
      OP_SUB: begin
        if (a_q >= b_q) begin
          res_c = RESW'(a_q - b_q);
        end else begin
          res_c = RESW'(b_q - a_q);
          neg_c = 1'b1;
        end
      end
      OP_MUL: res_c = RESW'(a_q) * RESW'(b_q);
      default: res_c = '0;
    endcase
  end

`ifdef DIV_EN
  logic [OPW-1:0]     rem_q;
  logic [OPW-1:0]     dvd_q;
  logic [DIVCNTW-1:0] dcnt_q;
  logic               err_q;
  logic [OPW-1:0]     rem_in_c;
  logic [OPW-1:0]     dvd_in_c;
  logic [OPW:0]       trial_c;
  logic [OPW-1:0]     rem_n_c;
  logic [OPW-1:0]     dvd_n_c;

  // One restoring-division step; CALC seeds it from A so the first step overlaps CALC.
  always_comb begin
    rem_in_c = (state_q == ST_CALC) ? '0 : rem_q;
    dvd_in_c = (state_q == ST_CALC) ? a_q : dvd_q;
    trial_c  = {rem_in_c, dvd_in_c[OPW-1]};
    rem_n_c  = trial_c[OPW-1:0];
    dvd_n_c  = {dvd_in_c[OPW-2:0], 1'b0};
    if (trial_c >= {1'b0, b_q}) begin
      rem_n_c = OPW'(trial_c - {1'b0, b_q});
      dvd_n_c = {dvd_in_c[OPW-2:0], 1'b1};
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    conv_start_c = 1'b0;
    conv_bin_c   = res_c;
    if (state_q == ST_CALC && op_q != OP_DIV) conv_start_c = 1'b1;
`ifdef DIV_EN
    if (state_q == ST_DIV && dcnt_q == '0) begin
      conv_start_c = 1'b1;
      conv_bin_c   = RESW'(dvd_q);
    end
`endif
  end

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .reset   (reset),
    .start_i (conv_start_c),
    .bin_i   (conv_bin_c),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      acnt_q  <= '0;
      bcnt_q  <= '0;
      op_q    <= OP_ADD;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
`ifdef DIV_EN
      rem_q   <= '0;
      dvd_q   <= '0;
      dcnt_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      rv_q <= 1'b0;
      if (key_c && key_code == KEY_ESC) begin
        state_q <= ST_ENTER_A;
        a_q     <= '0;
        b_q     <= '0;
        acnt_q  <= '0;
        bcnt_q  <= '0;
        op_q    <= OP_ADD;
        bcd_q   <= '0;
        neg_q   <= 1'b0;
`ifdef DIV_EN
        err_q   <= 1'b0;
`endif
      end else begin
        case (state_q)
          ST_ENTER_A: begin
            if (key_c && dig_c.hit) begin
              if (acnt_q < DIGW'(MAX_DIGITS)) begin
                a_q    <= push_digit(a_q, dig_c.val);
                acnt_q <= acnt_q + DIGW'(1);
                bcd_q  <= show_operand(bcd_q, acnt_q, dig_c.val);
              end
            end else if (key_c && opk_c.hit && acnt_q != '0) begin
              op_q    <= opk_c.op;
              bcd_q   <= '0;
              state_q <= ST_ENTER_B;
            end
          end
          ST_ENTER_B: begin
            if (key_c && dig_c.hit) begin
              if (bcnt_q < DIGW'(MAX_DIGITS)) begin
                b_q    <= push_digit(b_q, dig_c.val);
                bcnt_q <= bcnt_q + DIGW'(1);
                bcd_q  <= show_operand(bcd_q, bcnt_q, dig_c.val);
              end
            end else if (key_c && opk_c.hit && bcnt_q == '0) begin
              op_q <= opk_c.op;
            end else if (key_c && key_code == KEY_ENTER && bcnt_q != '0) begin
              state_q <= ST_CALC;
              busy_q  <= 1'b1;
            end
          end
          ST_CALC: begin
            neg_q   <= neg_c;
            state_q <= ST_CONVERT;
`ifdef DIV_EN
            if (op_q == OP_DIV) begin
              // Divide by zero bypasses the datapath and reports straight away.
              if (b_q == '0) begin
                state_q <= ST_SHOW;
                bcd_q   <= '0;
                err_q   <= 1'b1;
                rv_q    <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                state_q <= ST_DIV;
                rem_q   <= rem_n_c;
                dvd_q   <= dvd_n_c;
                dcnt_q  <= DIVCNTW'(DIV_CYCLES - 1);
              end
            end
`endif
          end
`ifdef DIV_EN
          ST_DIV: begin
            if (dcnt_q != '0) begin
              rem_q  <= rem_n_c;
              dvd_q  <= dvd_n_c;
              dcnt_q <= dcnt_q - DIVCNTW'(1);
            end else begin
              state_q <= ST_CONVERT;
            end
          end
`endif
          ST_CONVERT: begin
            if (conv_done) begin
              bcd_q   <= conv_bcd;
              rv_q    <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_SHOW;
            end
          end
          ST_SHOW: begin
            if (key_c && dig_c.hit) begin
              state_q <= ST_ENTER_A;
              a_q     <= OPW'(dig_c.val);
              acnt_q  <= DIGW'(1);
              b_q     <= '0;
              bcnt_q  <= '0;
              op_q    <= OP_ADD;
              bcd_q   <= BCDW'(dig_c.val);
              neg_q   <= 1'b0;
`ifdef DIV_EN
              err_q   <= 1'b0;
`endif
            end
          end
          default: state_q <= ST_ENTER_A;
        endcase
      end
    end
  end

  assign bcd          = bcd_q;
  assign neg          = neg_q;
  assign op           = op_q;
  assign busy         = busy_q;
  assign result_valid = rv_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: a key-level reference model predicts results and
// their arrival cycle; a negedge monitor checks every result_valid pulse. Honours DIV_EN.
`timescale 1ns/1ps
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  key_code;
  logic        key_valid;
  logic [15:0] bcd;
  logic        neg;
  logic [1:0]  op;
  logic        busy;
  logic        result_valid;
  logic        err;

  calc_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .bcd          (bcd),
    .neg          (neg),
    .op           (op),
    .busy         (busy),
    .result_valid (result_valid),
    .err          (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc = cyc + 1;

  localparam logic [7:0] K_ENTER = 8'h5A;
  localparam logic [7:0] K_ESC   = 8'h76;
  logic [7:0] dig_tab [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] op_tab  [4]  = '{8'h79, 8'h7B, 8'h22, 8'h4A};
  logic [7:0] junk_tab[4]  = '{8'h1C, 8'h00, 8'hF0, 8'h29};

`ifdef DIV_EN
  localparam int N_OPS = 4;
`else
  localparam int N_OPS = 3;
`endif

  typedef struct {
    logic [15:0] bcd;
    logic        neg;
    logic [1:0]  op;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Reference model state: phase 0 = entering A, 1 = entering B, 2 = showing a result.
  int m_phase, m_a, m_acnt, m_b, m_bcnt, m_op, m_disp, m_busy_until;
  bit m_neg, m_err;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int key_digit(input logic [7:0] c);
    for (int i = 0; i < 10; i++) if (dig_tab[i] == c) return i;
    return -1;
  endfunction

  function automatic int key_op(input logic [7:0] c);
    for (int i = 0; i < N_OPS; i++) if (op_tab[i] == c) return i;
    return -1;
  endfunction

  task automatic model_clear();
    m_phase = 0; m_a = 0; m_acnt = 0; m_b = 0; m_bcnt = 0;
    m_op = 0; m_disp = 0; m_neg = 0; m_err = 0;
  endtask

  task automatic model_compute();
    exp_t e;
    int   r, lat;
    e.op = 2'(m_op); e.neg = 1'b0; e.err = 1'b0; r = 0; lat = 16;
    case (m_op)
      0: r = m_a + m_b;
      1: if (m_a >= m_b) r = m_a - m_b; else begin r = m_b - m_a; e.neg = 1'b1; end
      2: r = m_a * m_b;
      default: begin
        if (m_b == 0) begin e.err = 1'b1; lat = 2; end
        else begin r = m_a / m_b; lat = 23; end
      end
    endcase
    e.bcd = to_bcd(r);
    e.due = cyc + lat;
    m_busy_until = cyc + lat - 1;
    sb.push_back(e);
    m_phase = 2; m_disp = r; m_neg = e.neg; m_err = e.err;
  endtask

  // Applies one key strobe issued in the current cycle; chk says whether the display is checkable next cycle.
  task automatic model_key(input logic [7:0] c, output bit chk);
    int d, o;
    d = key_digit(c);
    o = key_op(c);
    chk = 1'b0;
    if (cyc <= m_busy_until) return;
    chk = 1'b1;
    if (c == K_ESC) begin
      model_clear();
      return;
    end
    case (m_phase)
      0: begin
        if (d >= 0) begin
          if (m_acnt < 2) begin m_a = m_a * 10 + d; m_acnt++; end
          m_disp = m_a;
        end else if (o >= 0 && m_acnt >= 1) begin
          m_op = o; m_phase = 1; m_disp = 0;
        end
      end
      1: begin
        if (d >= 0) begin
          if (m_bcnt < 2) begin m_b = m_b * 10 + d; m_bcnt++; end
          m_disp = m_b;
        end else if (o >= 0) begin
          if (m_bcnt == 0) m_op = o;
        end else if (c == K_ENTER && m_bcnt >= 1) begin
          model_compute();
          chk = 1'b0;
        end
      end
      default: begin
        if (d >= 0) begin
          model_clear();
          m_a = d; m_acnt = 1; m_disp = d;
        end
      end
    endcase
  endtask

  task automatic check_disp(input string name);
    logic [20:0] got, exp;
    got = {bcd, neg, op, err, busy};
    exp = {to_bcd(m_disp), m_neg, 2'(m_op), m_err, 1'b0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got bcd=%h neg=%b op=%b err=%b busy=%b expected bcd=%h neg=%b op=%b err=%b busy=0",
               name, cyc, bcd, neg, op, err, busy, to_bcd(m_disp), m_neg, 2'(m_op), m_err);
    end
  endtask

  task automatic send_key(input logic [7:0] c);
    bit chk;
    model_key(c, chk);
    key_code  = c;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 8'h00;
    if (chk) check_disp("display");
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL result_timeout cyc=%0d got %0d results still pending required 0", cyc, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({bcd, neg, op, busy, result_valid, err} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs got bcd=%h neg=%b op=%b busy=%b rv=%b err=%b required all 0",
               bcd, neg, op, busy, result_valid, err);
    end
    sb.delete();
    model_clear();
    m_busy_until = -1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Every result pulse must match the oldest prediction, value and arrival cycle.
  always @(negedge clk) begin
    if (!reset && result_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result cyc=%0d got bcd=%h neg=%b err=%b required no result_valid", cyc, bcd, neg, err);
      end else begin
        mon_e = sb.pop_front();
        if ({bcd, neg, op, err} !== {mon_e.bcd, mon_e.neg, mon_e.op, mon_e.err} || cyc != mon_e.due) begin
          errors++;
          $display("FAIL result cyc=%0d got bcd=%h neg=%b op=%b err=%b required cyc=%0d bcd=%h neg=%b op=%b err=%b",
                   cyc, bcd, neg, op, err, mon_e.due, mon_e.bcd, mon_e.neg, mon_e.op, mon_e.err);
        end
      end
    end
  end

  initial begin
    int na, nb;
    reset = 1'b1; key_code = 8'h00; key_valid = 1'b0;
    model_clear();
    m_busy_until = -1;
    idle(2);
    do_reset();

    // 12 + 34 = 46
    send_key(dig_tab[1]); send_key(dig_tab[2]); send_key(op_tab[0]);
    send_key(dig_tab[3]); send_key(dig_tab[4]); send_key(K_ENTER);
    drain();
    // 5 - 9 = -4, then a digit starts fresh
    send_key(dig_tab[5]); send_key(op_tab[1]); send_key(dig_tab[9]); send_key(K_ENTER);
    drain();
    send_key(dig_tab[7]);
    // 99 * 99 = 9801
    send_key(K_ESC);
    send_key(dig_tab[9]); send_key(dig_tab[9]); send_key(op_tab[2]);
    send_key(dig_tab[9]); send_key(dig_tab[9]); send_key(K_ENTER);
    drain();
    // third digit ignored
    send_key(K_ESC);
    send_key(dig_tab[1]); send_key(dig_tab[2]); send_key(dig_tab[3]);
    // Esc after operator, then Enter without B digits
    send_key(K_ESC);
    send_key(dig_tab[4]); send_key(op_tab[0]); send_key(K_ESC);
    send_key(dig_tab[4]); send_key(op_tab[0]); send_key(K_ENTER);
    idle(20);
    // strobe during CONVERT is dropped
    send_key(K_ESC);
    send_key(dig_tab[2]); send_key(op_tab[2]); send_key(dig_tab[3]); send_key(K_ENTER);
    idle(5);
    send_key(dig_tab[8]);
    drain();
    // reset mid-CONVERT aborts
    send_key(K_ESC);
    send_key(dig_tab[1]); send_key(op_tab[0]); send_key(dig_tab[2]); send_key(K_ENTER);
    idle(6);
    do_reset();
    idle(25);
`ifdef DIV_EN
    send_key(dig_tab[8]); send_key(dig_tab[4]); send_key(op_tab[3]);
    send_key(dig_tab[5]); send_key(K_ENTER);
    drain();
    send_key(K_ESC);
    send_key(dig_tab[8]); send_key(op_tab[3]); send_key(dig_tab[0]); send_key(K_ENTER);
    drain();
    send_key(dig_tab[3]);
`endif

    // randomized calculations with ragged gaps so some strobes land while busy
    for (int it = 0; it < 120; it++) begin
      if ($urandom_range(0, 4) == 0) send_key(K_ESC);
      na = $urandom_range(0, 3);
      for (int j = 0; j < na; j++) send_key(dig_tab[$urandom_range(0, 9)]);
      send_key(op_tab[$urandom_range(0, N_OPS - 1)]);
      if ($urandom_range(0, 3) == 0) send_key(op_tab[$urandom_range(0, N_OPS - 1)]);
      nb = $urandom_range(0, 3);
      for (int j = 0; j < nb; j++) send_key(dig_tab[$urandom_range(0, 9)]);
      if ($urandom_range(0, 3) == 0) send_key(op_tab[$urandom_range(0, N_OPS - 1)]);
      if ($urandom_range(0, 5) == 0) send_key(junk_tab[$urandom_range(0, 3)]);
      send_key(K_ENTER);
      idle($urandom_range(0, 20));
    end
    drain();
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
